// File: rtl/vend_pkg.sv
// Shared vending types and constants: coin values, credit width, the vending
// controller state enum and the coin-intake FSM enum.
package vend_pkg;

  localparam int CREDIT_W  = 10;
  localparam int NUM_COINS = 4;

  localparam logic [CREDIT_W-1:0] COIN_5   = 10'd5;
  localparam logic [CREDIT_W-1:0] COIN_10  = 10'd10;
  localparam logic [CREDIT_W-1:0] COIN_25  = 10'd25;
  localparam logic [CREDIT_W-1:0] COIN_100 = 10'd100;

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_VEND, ST_CHANGE} state_t;

  typedef enum logic [1:0] {IN_IDLE, IN_APPLY, IN_REFUND} intake_state_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] idx);
    case (idx)
      2'd0:    return COIN_5;
      2'd1:    return COIN_10;
      2'd2:    return COIN_25;
      default: return COIN_100;
    endcase
  endfunction

endpackage

// File: rtl/coin_intake_if.sv
// Spend/refund handshake and credit reporting between coin_intake (slave)
// and the downstream vending FSM (master).
interface coin_intake_if
  import vend_pkg::*;
#(
  parameter int W = CREDIT_W
);
  logic         spend_req;
  logic [W-1:0] spend_amt;
  logic         refund_req;
  logic [W-1:0] credit;
  logic         credit_valid;
  logic         spend_ack;
  logic         spend_nak;
  logic [W-1:0] refund_amt;
  logic         refund_valid;
  logic         coin_reject;

  modport master (
    output spend_req, spend_amt, refund_req,
    input  credit, credit_valid, spend_ack, spend_nak, refund_amt, refund_valid, coin_reject
  );

  modport slave (
    input  spend_req, spend_amt, refund_req,
    output credit, credit_valid, spend_ack, spend_nak, refund_amt, refund_valid, coin_reject
  );
endinterface

// File: rtl/btn_debounce.sv
// One coin button: 2-flop synchronizer, optional debouncer, rising-edge detect.
// Debouncer present only when COIN_INTAKE_DEBOUNCE_EN is defined.
module btn_debounce
`ifdef COIN_INTAKE_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_TICKS = 2
)
`endif
(
  input  logic hz100,
  input  logic reset_n,
  input  logic btn_raw,
  output logic coin_evt
);
  logic [1:0] sync_q, sync_d;
  logic [1:0] rdy_q, rdy_d;
  logic       prev_q, prev_d;
  logic       armed_q, armed_d;
  logic       level;

`ifdef COIN_INTAKE_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) level_d = sync_q[1];
      else                                     cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
`else
  assign level = sync_q[1];
`endif

  // Edges only count once the button has been seen released after reset,
  // so a press held through reset is never credited.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    rdy_d   = {rdy_q[0], 1'b1};
    armed_d = armed_q | (rdy_q[1] & ~sync_q[1]);
    prev_d  = level;
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      rdy_q   <= '0;
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      rdy_q   <= rdy_d;
      armed_q <= armed_d;
      prev_q  <= prev_d;
    end
  end

  assign coin_evt = level & ~prev_q & armed_q;

endmodule

// File: rtl/coin_intake.sv
// Coin intake: four button front-ends feeding a credit register with spend,
// refund and a 1-deep pending coin. Debounce enabled by COIN_INTAKE_DEBOUNCE_EN.
module coin_intake
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT     = 995,
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic                 hz100,
  input  logic                 reset_n,
  input  logic [NUM_COINS-1:0] coin_btn,
  coin_intake_if.slave         bus
);
  if (MAX_CREDIT < 0 || MAX_CREDIT > 1023 || DEBOUNCE_TICKS < 1) begin : g_param_chk
    $error("coin_intake: MAX_CREDIT must be 0..1023 and DEBOUNCE_TICKS >= 1");
  end

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  logic [NUM_COINS-1:0] coin_evt;

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_btn
    btn_debounce
`ifdef COIN_INTAKE_DEBOUNCE_EN
      #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS))
`endif
      u_btn (
        .hz100    (hz100),
        .reset_n  (reset_n),
        .btn_raw  (coin_btn[i]),
        .coin_evt (coin_evt[i])
      );
  end

  intake_state_t       state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
  logic [CREDIT_W-1:0] pend_val_q, pend_val_d;
  logic                pend_vld_q, pend_vld_d;
  logic                credit_valid_q, credit_valid_d;
  logic                spend_ack_q, spend_ack_d;
  logic                spend_nak_q, spend_nak_d;
  logic                refund_valid_q, refund_valid_d;
  logic                coin_reject_q, coin_reject_d;

  logic [CREDIT_W-1:0] take_val, add_val;
  logic [CREDIT_W:0]   sum;
  logic                take_vld, take_multi, applying, busy;

  // Lowest-index event wins; any further simultaneous event is rejected.
  always_comb begin
    take_val = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--)
      if (coin_evt[i]) take_val = coin_value(2'(i));
  end

  assign take_vld   = |coin_evt;
  assign take_multi = |(coin_evt & (coin_evt - NUM_COINS'(1)));
  assign applying   = (state_q == IN_APPLY) && pend_vld_q;
  assign add_val    = applying ? pend_val_q : take_val;
  assign sum        = {1'b0, credit_q} + {1'b0, add_val};

  always_comb begin
    state_d        = IN_IDLE;
    credit_d       = credit_q;
    refund_amt_d   = refund_amt_q;
    pend_vld_d     = 1'b0;
    pend_val_d     = pend_val_q;
    credit_valid_d = 1'b0;
    spend_ack_d    = 1'b0;
    spend_nak_d    = 1'b0;
    refund_valid_d = 1'b0;
    coin_reject_d  = take_multi;
    busy           = 1'b0;

    if (applying) begin
      // Requests are held off by the requester while the pending coin drains.
      if (sum <= MAX_SUM) begin
        credit_d       = sum[CREDIT_W-1:0];
        credit_valid_d = 1'b1;
      end else begin
        coin_reject_d  = 1'b1;
      end
      if (take_vld) coin_reject_d = 1'b1;
    end else begin
      if (bus.refund_req) begin
        busy           = 1'b1;
        refund_amt_d   = credit_q;
        refund_valid_d = 1'b1;
        credit_d       = '0;
        credit_valid_d = |credit_q;
        state_d        = IN_REFUND;
      end else if (bus.spend_req) begin
        busy = 1'b1;
        if (bus.spend_amt <= credit_q) begin
          credit_d       = credit_q - bus.spend_amt;
          spend_ack_d    = 1'b1;
          credit_valid_d = |bus.spend_amt;
        end else begin
          spend_nak_d    = 1'b1;
        end
      end

      if (take_vld) begin
        if (busy) begin
          pend_vld_d = 1'b1;
          pend_val_d = take_val;
          state_d    = IN_APPLY;
        end else if (sum <= MAX_SUM) begin
          credit_d       = sum[CREDIT_W-1:0];
          credit_valid_d = 1'b1;
        end else begin
          coin_reject_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IN_IDLE;
      credit_q       <= '0;
      refund_amt_q   <= '0;
      pend_vld_q     <= 1'b0;
      pend_val_q     <= '0;
      credit_valid_q <= 1'b0;
      spend_ack_q    <= 1'b0;
      spend_nak_q    <= 1'b0;
      refund_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      refund_amt_q   <= refund_amt_d;
      pend_vld_q     <= pend_vld_d;
      pend_val_q     <= pend_val_d;
      credit_valid_q <= credit_valid_d;
      spend_ack_q    <= spend_ack_d;
      spend_nak_q    <= spend_nak_d;
      refund_valid_q <= refund_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.credit_valid = credit_valid_q;
  assign bus.spend_ack    = spend_ack_q;
  assign bus.spend_nak    = spend_nak_q;
  assign bus.refund_amt   = refund_amt_q;
  assign bus.refund_valid = refund_valid_q;
  assign bus.coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_coin_intake.sv
// Directed bench for coin_intake; expectations adapt to COIN_INTAKE_DEBOUNCE_EN.
module tb_coin_intake;
`ifdef COIN_INTAKE_DEBOUNCE_EN
  localparam int LAT = 5;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  logic       hz100;
  logic       reset_n;
  logic [3:0] coin_btn;
  int         checks   = 0;
  int         failures = 0;
  int         n_cv     = 0;
  int         n_rej    = 0;

  coin_intake_if #(.W(10)) bus ();

  coin_intake #(.MAX_CREDIT(995), .DEBOUNCE_TICKS(2)) dut (
    .hz100    (hz100),
    .reset_n  (reset_n),
    .coin_btn (coin_btn),
    .bus      (bus)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hz100);
    @(negedge hz100);
    if (bus.credit_valid) n_cv++;
    if (bus.coin_reject)  n_rej++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic coin(input logic [3:0] m);
    coin_btn = m;
    run(6);
    coin_btn = '0;
    run(6);
  endtask

  task automatic spend(input logic [9:0] amt);
    bus.spend_amt = amt;
    bus.spend_req = 1'b1;
    step();
    bus.spend_req = 1'b0;
  endtask

  initial begin
    coin_btn       = '0;
    bus.spend_req  = 1'b0;
    bus.spend_amt  = '0;
    bus.refund_req = 1'b0;
    reset_n        = 1'b0;
    @(negedge hz100);
    @(negedge hz100);
    chk("rst_credit", bus.credit, 0);
    chk("rst_pulses", {bus.credit_valid, bus.spend_ack, bus.spend_nak, bus.refund_valid, bus.coin_reject}, 0);
    chk("rst_refund_amt", bus.refund_amt, 0);
    reset_n = 1'b1;
    run(4);

    // 25c held 10 cycles: credit appears exactly LAT cycles after the press
    n_cv = 0; n_rej = 0;
    coin_btn = 4'b0100;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == LAT - 1) chk("lat_before", bus.credit, 0);
      if (k == LAT)     chk("lat_at", bus.credit, 25);
    end
    coin_btn = '0;
    run(6);
    chk("press_cv_count", n_cv, 1);
    chk("press_rej_count", n_rej, 0);

    // bounce 1,0,1,0 then held
    n_cv = 0;
    coin_btn = 4'b0100; step();
    coin_btn = 4'b0000; step();
    coin_btn = 4'b0100; step();
    coin_btn = 4'b0000; step();
    coin_btn = 4'b0100; run(8);
    coin_btn = '0;      run(6);
    chk("bounce_credit", bus.credit, DEB ? 50 : 100);
    chk("bounce_cv_count", n_cv, DEB ? 1 : 3);

    // refund everything
    bus.refund_req = 1'b1; step(); bus.refund_req = 1'b0;
    chk("refund_valid", bus.refund_valid, 1);
    chk("refund_amt", bus.refund_amt, DEB ? 50 : 100);
    chk("refund_credit", bus.credit, 0);
    chk("refund_cv", bus.credit_valid, 1);
    step();
    chk("refund_pulse_end", bus.refund_valid, 0);

    // climb to 990, then overflow reject and exact ceiling
    for (int i = 0; i < 9; i++) coin(4'b1000);
    for (int i = 0; i < 3; i++) coin(4'b0100);
    coin(4'b0010);
    coin(4'b0001);
    chk("credit_990", bus.credit, 990);
    n_cv = 0; n_rej = 0;
    coin(4'b0010);
    chk("ovf_credit", bus.credit, 990);
    chk("ovf_rej_count", n_rej, 1);
    chk("ovf_cv_count", n_cv, 0);
    n_cv = 0; n_rej = 0;
    coin(4'b0001);
    chk("ceiling_credit", bus.credit, 995);
    chk("ceiling_cv_count", n_cv, 1);
    chk("ceiling_rej_count", n_rej, 0);

    // spends
    spend(10'd895);
    chk("spend895_ack", {bus.spend_ack, bus.spend_nak, bus.credit_valid}, 3'b101);
    chk("spend895_credit", bus.credit, 100);
    spend(10'd75);
    chk("spend75_ack", {bus.spend_ack, bus.spend_nak, bus.credit_valid}, 3'b101);
    chk("spend75_credit", bus.credit, 25);
    spend(10'd50);
    chk("spend50_nak", {bus.spend_ack, bus.spend_nak, bus.credit_valid}, 3'b010);
    chk("spend50_credit", bus.credit, 25);
    spend(10'd0);
    chk("spend0_ack", {bus.spend_ack, bus.spend_nak, bus.credit_valid}, 3'b100);
    spend(10'd25);
    chk("spend_all_ack", {bus.spend_ack, bus.spend_nak, bus.credit_valid}, 3'b101);
    chk("spend_all_credit", bus.credit, 0);
    step();

    // refund of zero credit: no credit_valid
    bus.refund_req = 1'b1; step(); bus.refund_req = 1'b0;
    chk("refund0", {bus.refund_valid, bus.credit_valid}, 2'b10);
    chk("refund0_amt", bus.refund_amt, 0);
    step();

    // refund coinciding with a 5c event: coin pends and lands next cycle
    coin(4'b0100); coin(4'b0100); coin(4'b0010);
    chk("credit_60", bus.credit, 60);
    coin_btn = 4'b0001;
    run(LAT - 1);
    bus.refund_req = 1'b1; step(); bus.refund_req = 1'b0;
    chk("pend_refund", {bus.refund_valid, bus.credit_valid}, 2'b11);
    chk("pend_refund_amt", bus.refund_amt, 60);
    chk("pend_refund_credit", bus.credit, 0);
    step();
    chk("pend_apply_credit", bus.credit, 5);
    chk("pend_apply_cv", bus.credit_valid, 1);
    coin_btn = '0;
    run(6);

    // simultaneous 5c+10c: 5c taken, one reject
    n_rej = 0;
    coin_btn = 4'b0011;
    run(LAT);
    chk("multi_credit", bus.credit, 10);
    chk("multi_rej", bus.coin_reject, 1);
    coin_btn = '0;
    run(6);
    chk("multi_rej_count", n_rej, 1);

    // reset in the middle of a held 100c press
    coin_btn = 4'b1000;
    run(2);
    reset_n = 1'b0;
    run(2);
    chk("midrst_credit", bus.credit, 0);
    reset_n = 1'b1;
    n_cv = 0;
    run(10);
    chk("held_through_rst_credit", bus.credit, 0);
    chk("held_through_rst_cv", n_cv, 0);
    coin_btn = '0;
    run(6);
    coin(4'b1000);
    chk("repress_credit", bus.credit, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_intake.md
COIN_INTAKE -- requirements
Module: coin_intake

Interface
REQ-001 Parameter MAX_CREDIT, default 995, is the credit ceiling in cents and SHALL be at most 1023.
REQ-002 Parameter DEBOUNCE_TICKS, default 2, is the number of consecutive stable hz100 cycles before a button level is accepted.
REQ-003 Port hz100, input, 1 bit: the single clock, 100 Hz; all flops SHALL be on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port coin_btn, input, 4 bits: raw asynchronous coin buttons; bit0=5c, bit1=10c, bit2=25c, bit3=100c.
REQ-006 Port spend_req, input, 1 bit: one-cycle request from the downstream vending FSM to deduct spend_amt.
REQ-007 Port spend_amt, input, 10 bits: price in cents, sampled when spend_req=1.
REQ-008 Port refund_req, input, 1 bit: one-cycle request to return all credit.
REQ-009 Port credit, output, 10 bits: current credit in cents, registered.
REQ-010 Port credit_valid, output, 1 bit: one-cycle pulse in the first cycle a changed credit value is visible.
REQ-011 Port spend_ack and port spend_nak, outputs, 1 bit each: one-cycle spend result pulses.
REQ-012 Port refund_amt, output, 10 bits, and port refund_valid, output, 1 bit: refunded value and its one-cycle pulse.
REQ-013 Port coin_reject, output, 1 bit: one-cycle pulse when a coin is not credited.

Function
REQ-014 Each coin_btn bit SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector producing a one-cycle coin event.
REQ-015 Debouncer: the accepted level SHALL change only after the synchronized input differs from it for DEBOUNCE_TICKS consecutive cycles; any bounce SHALL restart the count.
REQ-016 Multiple coin events in one cycle: only the lowest-index event SHALL be taken; each other event SHALL produce coin_reject (one pulse total per cycle).
REQ-017 Event priority per cycle: refund_req, then spend_req, then coin event.
REQ-018 Refund: refund_amt<=credit, refund_valid=1, credit<=0 on the next edge; credit_valid SHALL pulse only if credit was non-zero.
REQ-019 Spend with spend_amt<=credit: credit<=credit-spend_amt and spend_ack=1 on the next edge; credit_valid SHALL pulse if spend_amt!=0.
REQ-020 Spend with spend_amt>credit: spend_nak=1 and credit unchanged.
REQ-021 A coin event coinciding with refund_req or spend_req SHALL be held in a 1-deep pending register and applied in the next cycle; a coin event arriving while pending is full SHALL produce coin_reject.
REQ-022 Coin apply: if credit+value<=MAX_CREDIT, credit<=credit+value with credit_valid=1; otherwise credit is unchanged with coin_reject=1 (no saturation, no wrap).
REQ-023 Addition SHALL be computed 11 bits wide before comparison.
REQ-024 Control FSM states: IDLE (no work), APPLY (apply the pending coin), REFUND; transitions IDLE->REFUND on refund_req, IDLE->APPLY when the pending register fills, both returning to IDLE after one cycle.
REQ-025 spend_req and refund_req are ignored while the FSM is in APPLY and SHALL be held by the requester until ack/nak/refund_valid.
REQ-026 Latency with DEBOUNCE_TICKS=2 and no contention: credit SHALL change exactly 5 cycles after a raw press that is held stable.

Reset
REQ-027 On reset_n=0: credit=0, the pending register empty, the FSM in IDLE, synchronizer, debouncer levels and counters cleared, all pulse outputs and refund_amt =0.
REQ-028 A reset asserted mid-press SHALL discard the press; the button SHALL be released and pressed again to be credited.

Configuration
REQ-029 Macro COIN_INTAKE_DEBOUNCE_EN defined: debounce per REQ-015.
REQ-030 Macro COIN_INTAKE_DEBOUNCE_EN undefined: debouncers are omitted, the edge detector uses the synchronizer output directly, DEBOUNCE_TICKS is unused, and latency is 3 cycles.

Structure
REQ-031 Shared package vend_pkg SHALL hold the coin-value constants (5, 10, 25, 100), the credit width (10), the existing vending state_t enum, and this block's intake FSM enum.
REQ-032 Sub-module btn_debounce (synchronizer, debouncer and edge detect for one bit) SHALL be instantiated 4 times.

Verification
REQ-033 Press 25c for 10 cycles from reset -> credit=25 at cycle 5, one credit_valid, no coin_reject.
REQ-034 25c input bouncing 1,0,1,0 then held high -> exactly one credit of 25.
REQ-035 credit=990, press 10c -> coin_reject, credit stays 990; then press 5c -> credit=995.
REQ-036 credit=100, spend_req with spend_amt=75 -> spend_ack, credit=25; spend_amt=50 -> spend_nak, credit=25.
REQ-037 credit=60, refund_req in the same cycle as a 5c coin event -> refund_amt=60, refund_valid, credit=0, then credit=5 with credit_valid.
REQ-038 reset_n low during a held 100c press, then released -> credit=0 with no credit until the button is pressed again.
